// File: rtl/arm_const.sv
// arm_const: shared ARM SoC constants and the text VRAM cell/fill types.
package arm_const;
  localparam int VGA_SCREEN_SIZE = 2400;
  typedef struct packed {
    logic [23:0] rgb;
    logic [7:0]  ascii;
  } vram_cell_t;
  typedef enum logic {VF_IDLE, VF_FILL} vram_fill_st_t;
endpackage

// File: rtl/vram_fill_fsm.sv
// vram_fill_fsm: screen fill engine, one cell per cycle, emits a write port ahead of the CPU.
module vram_fill_fsm import arm_const::*; #(
  parameter int DATA_W  = 32,
  parameter int CELLS   = VGA_SCREEN_SIZE,
  parameter int CELL_AW = $clog2(CELLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fill_start,
  input  logic [DATA_W-1:0]  fill_value,
  output logic               busy,
  output logic               done,
  output logic               fw_en,
  output logic [CELL_AW-1:0] fw_addr,
  output logic [DATA_W-1:0]  fw_data
);
  localparam logic [CELL_AW-1:0] LAST = CELL_AW'(CELLS - 1);
  vram_fill_st_t      r_st, w_nst;
  logic [CELL_AW-1:0] r_cnt, w_ncnt;
  logic [DATA_W-1:0]  r_val, w_nval;
  logic               r_done, w_ndone, w_go, w_last;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st   <= VF_IDLE;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_st   <= w_nst;
      r_cnt  <= w_ncnt;
      r_done <= w_ndone;
    end
    r_val <= w_nval;
  end
  always_comb begin
    w_go    = (r_st == VF_IDLE) && fill_start;
    w_last  = (r_st == VF_FILL) && (r_cnt == LAST);
    w_nst   = w_go ? VF_FILL : w_last ? VF_IDLE : r_st;
    w_ncnt  = (r_st == VF_FILL && !w_last) ? r_cnt + 1'b1 : '0;
    w_nval  = w_go ? fill_value : r_val;
    w_ndone = w_last;
  end
  assign busy    = (r_st == VF_FILL);
  assign done    = r_done;
  assign fw_en   = busy;
  assign fw_addr = r_cnt;
  assign fw_data = r_val;
endmodule

// File: rtl/text_vram.sv
// text_vram: character-cell VRAM with byte-enabled CPU port, registered video port and fill engine.
// Define VRAM_TRACE_EN for simulation-only write/fill trace output.
module text_vram import arm_const::*; #(
  parameter  int DATA_W  = 32,
  parameter  int CELLS   = VGA_SCREEN_SIZE,
  parameter  int ADDR_W  = 14,
  localparam int CELL_AW = $clog2(CELLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   a,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wd,
  output logic [DATA_W-1:0]   rd,
  input  logic [CELL_AW-1:0]  vid_addr,
  output logic [DATA_W-1:0]   vid_data,
  input  logic                fill_start,
  input  logic [DATA_W-1:0]   fill_value,
  output logic                busy,
  output logic                done
);
  logic [DATA_W-1:0]  r_mem [CELLS];
  logic [DATA_W-1:0]  r_rd, r_vid;
  logic [ADDR_W-3:0]  w_idx;
  logic [CELL_AW-1:0] w_cidx, w_fw_addr;
  logic [DATA_W-1:0]  w_fw_data;
  logic               w_idx_ok, w_vid_ok, w_cpu_we, w_fw_en, w_unused;
  assign w_idx    = a[ADDR_W-1:2];
  assign w_cidx   = CELL_AW'(w_idx);
  assign w_idx_ok = 32'(w_idx) < CELLS;
  assign w_vid_ok = 32'(vid_addr) < CELLS;
  assign w_cpu_we = we && !busy && w_idx_ok;
  assign w_unused = ^a[1:0];
  vram_fill_fsm #(.DATA_W(DATA_W), .CELLS(CELLS), .CELL_AW(CELL_AW)) u_fill (
    .clk        (clk),
    .reset      (reset),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .fw_en      (w_fw_en),
    .fw_addr    (w_fw_addr),
    .fw_data    (w_fw_data)
  );
  // Fill owns the write port while busy; CPU writes are already gated off then.
  always_ff @(posedge clk) begin
    if (w_fw_en)
      r_mem[w_fw_addr] <= w_fw_data;
    else if (w_cpu_we)
      for (int i = 0; i < DATA_W/8; i++)
        if (be[i]) r_mem[w_cidx][i*8 +: 8] <= wd[i*8 +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd  <= '0;
      r_vid <= '0;
    end else begin
      if (re) r_rd <= w_idx_ok ? r_mem[w_cidx] : '0;
      r_vid <= w_vid_ok ? r_mem[vid_addr] : '0;
    end
  end
  assign rd       = r_rd;
  assign vid_data = r_vid;
`ifdef VRAM_TRACE_EN
  vram_cell_t w_wcell;
  assign w_wcell = vram_cell_t'(wd[31:0]);
  always_ff @(posedge clk) begin
    if (!reset && w_cpu_we)
      $display("[VRAM] write a=%h d=%h be=%b ch='%c' rgb=%h", a, wd, be, w_wcell.ascii, w_wcell.rgb);
    if (!reset && fill_start && !busy)
      $display("[VRAM] fill start value=%h", fill_value);
    if (!reset && done)
      $display("[VRAM] fill done");
  end
`else
  // trace disabled: no simulation output
`endif
endmodule

// File: tb/tb_text_vram.sv
// tb_text_vram: directed vector table plus fill/reset sequences for text_vram.
module tb_text_vram;
  localparam int CELLS = 2400;
  localparam int AW    = 14;
  localparam int CAW   = $clog2(CELLS);
  logic            clk = 0, reset = 1, we = 0, re = 0, fill_start = 0;
  logic [AW-1:0]   a = '0;
  logic [3:0]      be = '0;
  logic [31:0]     wd = '0, fill_value = '0, rd, vid_data, got;
  logic [CAW-1:0]  vid_addr = '0;
  logic            busy, done;
  int              tests = 0, fails = 0, cnt;

  text_vram #(.DATA_W(32), .CELLS(CELLS), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .a(a), .be(be), .wd(wd), .rd(rd),
    .vid_addr(vid_addr), .vid_data(vid_data), .fill_start(fill_start),
    .fill_value(fill_value), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we, re;
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [11:0] va;
    logic        crd;
    logic [31:0] erd;
    logic        cvid;
    logic [31:0] evid;
  } vec_t;
  vec_t v[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_cell(input int idx, output logic [31:0] val);
    re = 1; a = AW'(idx * 4);
    @(negedge clk);
    re = 0;
    val = rd;
  endtask

  initial begin
    v[0]  = '{1, 0, 14'h0008, 4'hF, 32'h00FF0041, 12'd2,    1, 32'h0,        0, 32'h0};
    v[1]  = '{0, 1, 14'h0008, 4'h0, 32'h0,        12'd2,    1, 32'h00FF0041, 1, 32'h00FF0041};
    v[2]  = '{0, 0, 14'h0000, 4'h0, 32'h0,        12'd2,    1, 32'h00FF0041, 1, 32'h00FF0041};
    v[3]  = '{1, 0, 14'h0009, 4'hF, 32'h11223344, 12'd2,    1, 32'h00FF0041, 1, 32'h00FF0041};
    v[4]  = '{1, 0, 14'h0008, 4'h5, 32'hAABBCCDD, 12'd2,    1, 32'h00FF0041, 1, 32'h11223344};
    v[5]  = '{0, 1, 14'h0008, 4'h0, 32'h0,        12'd2,    1, 32'h11BB33DD, 1, 32'h11BB33DD};
    v[6]  = '{1, 1, 14'(CELLS*4), 4'hF, 32'hDEADBEEF, 12'(CELLS), 1, 32'h0, 1, 32'h0};
    v[7]  = '{0, 1, 14'h3FFC, 4'h0, 32'h0,        12'd2,    1, 32'h0,        1, 32'h11BB33DD};
    v[8]  = '{1, 0, 14'h001C, 4'hF, 32'h07070707, 12'd7,    1, 32'h0,        0, 32'h0};
    v[9]  = '{1, 0, 14'h001E, 4'hF, 32'h12345678, 12'd7,    0, 32'h0,        1, 32'h07070707};
    v[10] = '{1, 0, 14'h001C, 4'h0, 32'hFFFFFFFF, 12'd7,    0, 32'h0,        1, 32'h12345678};
    v[11] = '{0, 1, 14'h001C, 4'h0, 32'h0,        12'd7,    1, 32'h12345678, 1, 32'h12345678};

    @(negedge clk); @(negedge clk);
    chk("reset_rd", rd, 0);
    chk("reset_vid", vid_data, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    reset = 0;

    for (int i = 0; i < 12; i++) begin
      we = v[i].we; re = v[i].re; a = v[i].a; be = v[i].be; wd = v[i].wd; vid_addr = v[i].va;
      @(negedge clk);
      if (v[i].crd)  chk($sformatf("vec%0d_rd", i), rd, v[i].erd);
      if (v[i].cvid) chk($sformatf("vec%0d_vid", i), vid_data, v[i].evid);
    end
    we = 0; re = 0; be = 0;

    // fill with a coincident CPU write to cell 3, then disturb it while busy
    fill_start = 1; fill_value = 32'h20; we = 1; a = 14'h000C; be = 4'hF; wd = 32'h33;
    @(negedge clk);
    fill_start = 0; we = 0;
    cnt = 0;
    while (busy && cnt < 3 * CELLS) begin
      cnt++;
      if (cnt == 2) begin we = 1; a = 14'h0014; wd = 32'h55; end
      if (cnt == 3) begin we = 0; fill_start = 1; fill_value = 32'h99; end
      if (cnt == 4) fill_start = 0;
      if (cnt == 10) vid_addr = 0;
      if (cnt == 11) chk("vid_during_fill", vid_data, 32'h20);
      @(negedge clk);
    end
    chk("fill_busy_cycles", cnt, CELLS);
    chk("fill_done_pulse", {31'b0, done}, 1);
    chk("fill_busy_low", {31'b0, busy}, 0);
    @(negedge clk);
    chk("fill_done_one_cycle", {31'b0, done}, 0);
    chk("second_start_ignored", {31'b0, busy}, 0);
    read_cell(0, got);         chk("fill_cell0", got, 32'h20);
    read_cell(3, got);         chk("fill_cell3", got, 32'h20);
    read_cell(5, got);         chk("fill_cell5", got, 32'h20);
    read_cell(CELLS - 1, got); chk("fill_cell_last", got, 32'h20);

    // reset mid-fill
    fill_start = 1; fill_value = 32'hAB;
    @(negedge clk);
    fill_start = 0; vid_addr = 0;
    repeat (5) @(negedge clk);
    chk("midfill_busy", {31'b0, busy}, 1);
    chk("midfill_rd_nonzero", rd, 32'h20);
    reset = 1;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_rd", rd, 0);
    chk("rst_vid", vid_data, 0);
    reset = 0;
    @(negedge clk);
    chk("rst_no_done", {31'b0, done}, 0);
    read_cell(0, got);     chk("rst_cell0_kept", got, 32'hAB);
    read_cell(100, got);   chk("rst_cell100_old", got, 32'h20);
    read_cell(CELLS, got); chk("oob_read", got, 0);
    chk("idle_no_done", {31'b0, done}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
